// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX FIFO + shifter, single-byte RX holding register, status, baud divisor.
// Optional build macro UART_LOOPBACK_EN feeds the RX engine from the internal TX line instead of uart_rxd.
`timescale 1ns/1ps
module uart_mmio #(
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_sel,
    input  logic        uart_write,
    input  logic [15:0] uart_addr,
    input  logic [31:0] uart_wdata,
    output logic [31:0] uart_rdata,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int          AW        = $clog2(TX_FIFO_DEPTH);
    localparam logic [AW:0] FIFO_FULL = (AW + 1)'(TX_FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [15:0] DIV_RST   = 16'(CLOCK_FREQ / BAUD_RATE);

    localparam logic [1:0] A_TXDATA  = 2'd0;
    localparam logic [1:0] A_RXDATA  = 2'd1;
    localparam logic [1:0] A_STATUS  = 2'd2;
    localparam logic [1:0] A_BAUDDIV = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // A divisor below 2 would leave no room for the half-bit start check.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

    logic        wr_tx, wr_rx, wr_st, wr_div;
    logic [15:0] div;
    logic [7:0]  rx_byte;
    logic        rx_valid, overrun, ferr;

    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          tx_full, tx_empty, tx_pop, push_ok;

    logic [1:0]  tx_state;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        txd_q, tx_bit_end, tx_busy;

    logic        rx_in, rx_s1, rx_s2, rx_s3;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt, rx_div, rx_target;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_tick, rx_done_ok, rx_done_err;

    logic unused_bits;
    assign unused_bits = ^{uart_addr[15:4], uart_addr[1:0], uart_wdata[31:16]};

    assign wr_tx  = uart_sel && uart_write && (uart_addr[3:2] == A_TXDATA);
    assign wr_rx  = uart_sel && uart_write && (uart_addr[3:2] == A_RXDATA);
    assign wr_st  = uart_sel && uart_write && (uart_addr[3:2] == A_STATUS);
    assign wr_div = uart_sel && uart_write && (uart_addr[3:2] == A_BAUDDIV);

    // TX FIFO: a push into a full FIFO survives only when the shifter pops in the same cycle.
    assign tx_full  = (count == FIFO_FULL);
    assign tx_empty = (count == '0);
    assign push_ok  = wr_tx && (!tx_full || tx_pop);
    assign tx_pop   = !tx_empty && ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_bit_end));

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= uart_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (tx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, tx_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // TX engine: each bit lasts tx_div cycles; tx_div is refreshed from div at every bit boundary.
    assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
    assign tx_busy    = (tx_state != S_IDLE);
    assign uart_txd   = txd_q;

    always_ff @(posedge clk) begin
        if (tx_pop)
            tx_shift <= fifo_mem[rd_ptr];
        else if ((tx_state == S_START || tx_state == S_DATA) && tx_bit_end)
            tx_shift <= tx_shift >> 1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            txd_q    <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_div   <= DIV_RST;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx_cnt <= '0;
                    if (!tx_empty) begin
                        tx_state <= S_START;
                        txd_q    <= 1'b0;
                        tx_div   <= div;
                    end
                end
                S_START: begin
                    if (tx_bit_end) begin
                        tx_state <= S_DATA;
                        txd_q    <= tx_shift[0];
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_div   <= div;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        tx_div <= div;
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            txd_q    <= 1'b1;
                        end else begin
                            txd_q <= tx_shift[0];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        tx_div <= div;
                        if (!tx_empty) begin
                            tx_state <= S_START;
                            txd_q    <= 1'b0;
                        end else begin
                            tx_state <= S_IDLE;
                            txd_q    <= 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

`ifdef UART_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = uart_rxd;
    assign rx_in      = txd_q;
`else
    assign rx_in = uart_rxd;
`endif

    // RX synchronizer; rx_s3 only remembers the previous synchronized level for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_target   = (rx_state == S_START) ? ((rx_div >> 1) - 16'd1) : (rx_div - 16'd1);
    assign rx_tick     = (rx_cnt == rx_target);
    assign rx_done_ok  = (rx_state == S_STOP) && rx_tick && rx_s2;
    assign rx_done_err = (rx_state == S_STOP) && rx_tick && !rx_s2;

    always_ff @(posedge clk) begin
        if (rx_state == S_DATA && rx_tick) rx_shift <= {rx_s2, rx_shift[7:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_div   <= DIV_RST;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_s3 && !rx_s2) begin
                        rx_state <= S_START;
                        rx_div   <= div;
                    end
                end
                S_START: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_div   <= div;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        rx_div <= div;
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // Hardware events win over same-cycle software clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            div      <= DIV_RST;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            if (wr_div) div <= clamp_div(uart_wdata[15:0]);
            if (rx_done_ok) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (wr_rx) begin
                rx_valid <= 1'b0;
            end
            if (rx_done_ok && rx_valid && !wr_rx) overrun <= 1'b1;
            else if (wr_st && uart_wdata[4])      overrun <= 1'b0;
            if (rx_done_err)                 ferr <= 1'b1;
            else if (wr_st && uart_wdata[5]) ferr <= 1'b0;
        end
    end

    always_comb begin
        uart_rdata = '0;
        if (uart_sel) begin
            case (uart_addr[3:2])
                A_RXDATA:  uart_rdata = {24'b0, rx_byte};
                A_STATUS:  uart_rdata = {26'b0, ferr, overrun, rx_valid, tx_busy, tx_empty, tx_full};
                A_BAUDDIV: uart_rdata = {16'b0, div};
                default:   uart_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed + randomized bench for uart_mmio; expected TX waveforms and RX status come from a frame-level model.
`timescale 1ns/1ps
module tb_uart_mmio;

    logic        clk = 1'b0;
    logic        reset, uart_sel, uart_write, uart_rxd, uart_txd;
    logic [15:0] uart_addr;
    logic [31:0] uart_wdata, uart_rdata;

    int total = 0;
    int bad   = 0;

    logic       txd_log [$];
    logic [7:0] tx_bytes [$];
    bit         logging = 0;

    logic [7:0] m_byte;
    bit         m_valid, m_ovr, m_ferr;

    always #5 clk = ~clk;

    uart_mmio dut (
        .clk(clk), .reset(reset), .uart_sel(uart_sel), .uart_write(uart_write),
        .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_rdata(uart_rdata),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    always @(negedge clk) if (logging) txd_log.push_back(uart_txd);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        uart_sel = 1'b1; uart_write = 1'b1; uart_addr = a; uart_wdata = d;
        @(posedge clk);
        #1;
        uart_sel = 1'b0; uart_write = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        uart_sel = 1'b1; uart_write = 1'b0; uart_addr = a;
        #1;
        d = uart_rdata;
        uart_sel = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [15:0] a, input logic [31:0] exp,
                           input logic [31:0] mask = 32'hFFFF_FFFF);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d & mask, exp);
    endtask

    // Push tx_bytes on consecutive cycles; logging starts the cycle after the first push.
    task automatic push_bytes();
        foreach (tx_bytes[i]) begin
            bus_write(16'h0, {24'b0, tx_bytes[i]});
            if (i == 0) begin
                txd_log.delete();
                logging = 1;
            end
        end
    endtask

    // Expected line: one idle cycle, then contiguous 8N1 frames, then idle; compared one bit cell at a time.
    task automatic check_tx(input string tag, input int dv);
        int idx;
        logic b;
        logic [15:0] got, exp;
        chk({tag, " lead"}, 32'(txd_log[0]), 32'd1);
        idx = 1;
        foreach (tx_bytes[f]) begin
            for (int c = 0; c < 11; c++) begin
                if (c == 10 && f != tx_bytes.size() - 1) break;
                b = (c == 0) ? 1'b0 : (c >= 9) ? 1'b1 : tx_bytes[f][c-1];
                got = '0; exp = '0;
                for (int k = 0; k < dv; k++) begin
                    got[k] = txd_log[idx + k];
                    exp[k] = b;
                end
                idx += dv;
                chk($sformatf("%s f%0d c%0d", tag, f, c), 32'(got), 32'(exp));
            end
        end
        logging = 0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int dv);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = fr[i];
            wait_cyc(dv);
        end
        uart_rxd = 1'b1;
        wait_cyc(dv + 2);
    endtask

    task automatic rx_model(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (m_valid) m_ovr = 1;
            m_valid = 1;
            m_byte  = b;
        end else begin
            m_ferr = 1;
        end
    endtask

    function automatic logic [31:0] m_status();
        return {26'b0, m_ferr, m_ovr, m_valid, 3'b010};
    endfunction

    initial begin
        int dv, n;
        logic [7:0] b;
        logic st;
        reset = 1'b1; uart_sel = 1'b0; uart_write = 1'b0;
        uart_addr = '0; uart_wdata = '0; uart_rxd = 1'b1;
        m_byte = '0; m_valid = 0; m_ovr = 0; m_ferr = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst txd", 32'(uart_txd), 32'd1);
        chk_reg("rst status", 16'h8, 32'h02);
        chk_reg("rst div", 16'hC, 32'd434);
        chk_reg("rst rxdata", 16'h4, 32'h0);
        chk_reg("txdata read", 16'h0, 32'h0);
        uart_addr = 16'hC; uart_sel = 1'b0;
        #1 chk("unsel rdata", uart_rdata, 32'h0);

        bus_write(16'hC, 32'h0);
        chk_reg("div clamp 0", 16'hC, 32'd2);
        bus_write(16'hC, 32'h1);
        chk_reg("div clamp 1", 16'hC, 32'd2);
        bus_write(16'hC, 32'hABCD_0003);
        chk_reg("div low half", 16'hC, 32'd3);

        // Single byte at div=4
        bus_write(16'hC, 32'd4);
        tx_bytes = '{8'h55};
        push_bytes();
        chk_reg("tx load lat", 16'h8, 32'h0, 32'h7);
        wait_cyc(1);
        chk_reg("tx busy start", 16'h8, 32'h6, 32'h7);
        wait_cyc(39);
        chk_reg("tx busy last", 16'h8, 32'h6, 32'h7);
        wait_cyc(1);
        chk_reg("tx idle", 16'h8, 32'h2, 32'h7);
        wait_cyc(6);
        check_tx("tx55", 4);

        // FIFO full: 0x09 and 0x77 dropped, 0xAA accepted because it lands on a pop cycle
        tx_bytes = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        for (int i = 0; i < 10; i++) begin
            if (i == 9) chk_reg("fifo full", 16'h8, 32'h5, 32'h7);
            bus_write(16'h0, i);
            if (i == 0) begin
                txd_log.delete();
                logging = 1;
            end
        end
        chk_reg("fifo drop", 16'h8, 32'h5, 32'h7);
        wait_cyc(30);
        bus_write(16'h0, 32'h77);
        bus_write(16'h0, 32'hAA);
        chk_reg("fifo push on pop", 16'h8, 32'h5, 32'h7);
        tx_bytes.push_back(8'hAA);
        wait_cyc(370);
        check_tx("fifo", 4);
        chk_reg("fifo drained", 16'h8, 32'h2, 32'h7);

        for (int it = 0; it < 3; it++) begin
            dv = $urandom_range(2, 6);
            n  = $urandom_range(1, 5);
            bus_write(16'hC, dv);
            tx_bytes.delete();
            for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
            push_bytes();
            wait_cyc(n * 10 * dv + dv + 4);
            check_tx($sformatf("rnd%0d", it), dv);
            chk_reg("rnd idle", 16'h8, 32'h2, 32'h7);
        end

        // Reset in the middle of a frame with bytes still queued
        bus_write(16'hC, 32'd4);
        bus_write(16'h0, 32'hF0);
        bus_write(16'h0, 32'h0F);
        bus_write(16'h0, 32'h33);
        wait_cyc(10);
        reset = 1'b1;
        wait_cyc(1);
        chk("midrst txd", 32'(uart_txd), 32'd1);
        reset = 1'b0;
        chk_reg("midrst status", 16'h8, 32'h02);
        chk_reg("midrst div", 16'hC, 32'd434);
        wait_cyc(50);
        chk("midrst quiet", 32'(uart_txd), 32'd1);
        chk_reg("midrst fifo gone", 16'h8, 32'h02);

`ifndef UART_LOOPBACK_EN
        bus_write(16'hC, 32'd8);
        send_rx(8'hA3, 1'b1, 8); rx_model(8'hA3, 1'b1);
        chk_reg("rx A3", 16'h4, 32'hA3);
        chk_reg("rx A3 st", 16'h8, m_status());
        send_rx(8'h3C, 1'b1, 8); rx_model(8'h3C, 1'b1);
        chk_reg("rx 3C", 16'h4, 32'h3C);
        chk_reg("rx ovr st", 16'h8, m_status());
        bus_write(16'h8, 32'h10); m_ovr = 0;
        chk_reg("ovr w1c", 16'h8, m_status());
        bus_write(16'h4, 32'h0); m_valid = 0;
        chk_reg("rxvalid clr", 16'h8, m_status());
        send_rx(8'h5A, 1'b0, 8); rx_model(8'h5A, 1'b0);
        chk_reg("ferr st", 16'h8, m_status());
        chk_reg("ferr keep byte", 16'h4, {24'b0, m_byte});
        uart_rxd = 1'b0;
        wait_cyc(2);
        uart_rxd = 1'b1;
        wait_cyc(20);
        chk_reg("glitch st", 16'h8, m_status());
        chk_reg("glitch byte", 16'h4, {24'b0, m_byte});
        bus_write(16'h8, 32'h20); m_ferr = 0;
        chk_reg("ferr w1c", 16'h8, m_status());

        for (int it = 0; it < 8; it++) begin
            dv = $urandom_range(4, 10);
            b  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            bus_write(16'hC, dv);
            send_rx(b, st, dv);
            rx_model(b, st);
            chk_reg($sformatf("rnd rx%0d byte", it), 16'h4, {24'b0, m_byte});
            chk_reg($sformatf("rnd rx%0d st", it), 16'h8, m_status());
            case ($urandom_range(0, 2))
                1: begin bus_write(16'h4, 32'h0); m_valid = 0; end
                2: begin bus_write(16'h8, 32'h30); m_ovr = 0; m_ferr = 0; end
                default: ;
            endcase
        end
`else
        bus_write(16'hC, 32'd6);
        uart_rxd = 1'b0;
        bus_write(16'h0, 32'hC7); rx_model(8'hC7, 1'b1);
        wait_cyc(80);
        chk_reg("lb C7", 16'h4, 32'hC7);
        chk_reg("lb C7 st", 16'h8, m_status());
        for (int it = 0; it < 4; it++) begin
            b = 8'($urandom);
            if (it == 2) begin bus_write(16'h4, 32'h0); m_valid = 0; end
            bus_write(16'h0, {24'b0, b}); rx_model(b, 1'b1);
            wait_cyc(80);
            chk_reg($sformatf("lb rnd%0d byte", it), 16'h4, {24'b0, m_byte});
            chk_reg($sformatf("lb rnd%0d st", it), 16'h8, m_status());
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
